add_pipe: RTL and testbench
===========================

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter N, default 4: signed operand width, N >= 2.
REQ-002 SHALL have parameter ACC_W, default 8: accumulator and result width, ACC_W >= N+1.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port op, input, 2: 00 ADD (X+Y), 01 SUB (X-Y), 10 ACC (acc+X), 11 CLR (acc<=0).
REQ-008 SHALL have port X, input, N: signed operand.
REQ-009 SHALL have port Y, input, N: signed operand, ignored for ACC and CLR.
REQ-010 SHALL have port out_valid, output, 1: result beat present.
REQ-011 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-012 SHALL have port S, output, ACC_W: signed result, sign-extended.
REQ-013 SHALL have port ovf, output, 1: accumulator overflow flag, qualified by out_valid.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers op/X/Y; stage 2 computes and registers S/ovf/out_valid.
REQ-015 SHALL present an accepted beat on S/out_valid exactly 2 cycles after acceptance when out_ready stays high.
REQ-016 SHALL define stall = out_valid && !out_ready; the whole pipeline holds all registers while stall is 1.
REQ-017 SHALL drive in_ready = !stall, combinationally.
REQ-018 SHALL sustain one beat per cycle with no bubbles while out_ready stays high.
REQ-019 SHALL hold S, ovf and out_valid stable while stall is 1.
REQ-020 SHALL compute ADD/SUB at N+1 bits, sign-extended to ACC_W; never overflows; ovf=0; acc unchanged.
REQ-021 SHALL, for ACC, compute acc + sext(X) at ACC_W+1 bits; ovf=1 if the true sum is outside the ACC_W signed range.
REQ-022 SHALL, for ACC, update acc and set S = new acc value in the same stage-2 update.
REQ-023 SHALL, for CLR, set acc to 0 and output S=0, ovf=0.
REQ-024 SHALL make back-to-back ACC beats see the acc value written by the preceding beat, with no stall or bubble.
REQ-025 SHALL deliver results in acceptance order; beats are never dropped or duplicated.
REQ-026 SHALL clear out_valid after an output handshake when no new beat reaches stage 2 that cycle.

Reset
REQ-027 SHALL, on rst_n low, immediately clear stage-1 valid, out_valid, S, ovf and acc to 0, independent of clk.
REQ-028 SHALL drive in_ready=1 during reset and on the first cycle after rst_n rises.
REQ-029 SHALL discard in-flight beats when reset asserts mid-operation; no result appears after release.

Configuration
REQ-030 SHALL, with macro ADD_PIPE_SAT_EN defined, saturate ACC results to 2^(ACC_W-1)-1 or -2^(ACC_W-1) on overflow, store the clamped value in acc, and set ovf=1.
REQ-031 SHALL, without ADD_PIPE_SAT_EN, wrap ACC results modulo 2^ACC_W, store the wrapped value in acc, and set ovf=1 on overflow.
REQ-032 SHALL leave ADD/SUB/CLR behaviour identical in both builds.

Verification
REQ-033 SHALL be verified by: ADD X=4, Y=3, out_ready=1 -> 2 cycles later out_valid=1, S=7, ovf=0.
REQ-034 SHALL be verified by: SUB X=-8, Y=7 -> S=-15, ovf=0, acc unchanged.
REQ-035 SHALL be verified by: CLR, then 19 back-to-back ACC with X=7 -> 18th S=126; 19th S=-123, ovf=1 (wrap build) or S=127, ovf=1 (ADD_PIPE_SAT_EN build).
REQ-036 SHALL be verified by: two beats (ADD 1+1, ADD 2+2) in flight, out_ready=0 for 3 cycles -> in_ready=0, S=2 held stable; out_ready=1 -> S=2 then S=4 on consecutive cycles, no loss.
REQ-037 SHALL be verified by: rst_n pulsed low while 2 ACC beats are in flight -> out_valid=0 immediately, no stale output; after release, ACC X=-3 -> S=-3.

Source files
------------

// File: rtl/add_pipe.sv
// Two-stage signed add/sub/accumulate pipeline with valid/ready flow control.
// Optional macro ADD_PIPE_SAT_EN: ACC results saturate on overflow instead of wrapping.
module add_pipe #(
  parameter int N     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [N-1:0]     X,
  input  logic [N-1:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] S,
  output logic             ovf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Handshake: a beat moves on a port when valid && ready in the same cycle.
  // The only back-pressure source is an unconsumed result, which freezes both stages.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic                    v1;
  op_e                     op1;
  logic signed [N-1:0]     x1;
  logic signed [N-1:0]     y1;
  logic signed [ACC_W-1:0] acc;

  logic signed [N:0]       addsub;
  logic signed [ACC_W:0]   accsum;
  logic signed [ACC_W-1:0] s_next;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf_next;

`ifdef ADD_PIPE_SAT_EN
  localparam logic signed [ACC_W-1:0] sat_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] sat_min = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  always_comb begin
    addsub   = '0;
    accsum   = '0;
    s_next   = '0;
    acc_next = acc;
    ovf_next = 1'b0;
    case (op1)
      OP_ADD: begin
        addsub = (N+1)'(x1) + (N+1)'(y1);
        s_next = ACC_W'(addsub);
      end
      OP_SUB: begin
        addsub = (N+1)'(x1) - (N+1)'(y1);
        s_next = ACC_W'(addsub);
      end
      OP_ACC: begin
        // One guard bit: the two top bits disagree exactly when the sum left the ACC_W range.
        accsum   = (ACC_W+1)'(acc) + (ACC_W+1)'(x1);
        ovf_next = accsum[ACC_W] ^ accsum[ACC_W-1];
`ifdef ADD_PIPE_SAT_EN
        if (ovf_next) s_next = accsum[ACC_W] ? sat_min : sat_max;
        else          s_next = accsum[ACC_W-1:0];
`else
        s_next   = accsum[ACC_W-1:0];
`endif
        acc_next = s_next;
      end
      OP_CLR: begin
        acc_next = '0;
      end
      default: begin
        s_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      op1 <= OP_ADD;
      x1  <= '0;
      y1  <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        op1 <= op_e'(op);
        x1  <= X;
        y1  <= Y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        S   <= s_next;
        ovf <= ovf_next;
        acc <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: directed scenarios plus random traffic checked against an integer model.
module tb_add_pipe;
  localparam int N     = 4;
  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << (ACC_W-1)) - 1;
  localparam int MINV  = -(1 << (ACC_W-1));

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [N-1:0]     X;
  logic [N-1:0]     Y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] S;
  logic             ovf;

  add_pipe #(.N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {ovf, S}.
  logic [ACC_W:0] exp_q[$];
  int             m_acc = 0;
  int             last_s = 0;
  int             prev_s = 0;
  logic           last_ovf = 1'b0;
  logic           was_stall = 1'b0;
  logic [ACC_W-1:0] held_s;
  logic           held_ovf;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int   xi;
    int   yi;
    int   t;
    logic v;
    xi = int'($signed(x));
    yi = int'($signed(y));
    t  = 0;
    v  = 1'b0;
    case (o)
      2'b00: t = xi + yi;
      2'b01: t = xi - yi;
      2'b10: begin
        t = m_acc + xi;
        if (t > MAXV || t < MINV) begin
          v = 1'b1;
`ifdef ADD_PIPE_SAT_EN
          t = (t > MAXV) ? MAXV : MINV;
`else
          while (t > MAXV) t = t - (1 << ACC_W);
          while (t < MINV) t = t + (1 << ACC_W);
`endif
        end
        m_acc = t;
      end
      default: begin
        m_acc = 0;
        t     = 0;
      end
    endcase
    return {v, t[ACC_W-1:0]};
  endfunction

  // One cycle: drive inputs just after the falling edge, check mid-cycle, then advance.
  task automatic tick(input logic v, input logic [1:0] o, input logic [N-1:0] x,
                      input logic [N-1:0] y, input logic ordy);
    logic [ACC_W:0] e;
    in_valid  = v;
    op        = o;
    X         = x;
    Y         = y;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (was_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_S", $signed(S), $signed(held_s));
      chk("hold_ovf", ovf, held_ovf);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("S", $signed(S), $signed(e[ACC_W-1:0]));
        chk("ovf", ovf, e[ACC_W]);
        prev_s   = last_s;
        last_s   = int'($signed(S));
        last_ovf = ovf;
      end
    end
    was_stall = out_valid && !out_ready;
    held_s    = S;
    held_ovf  = ovf;
    if (v && in_ready) exp_q.push_back(model(o, x, y));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1'b0, 2'b00, '0, '0, 1'b1);
    tick(1'b0, 2'b00, '0, '0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    X         = '0;
    Y         = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_S", $signed(S), 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_in_ready", in_ready, 1'b1);

    // Latency: result appears two cycles after acceptance.
    tick(1'b1, 2'b00, N'(4), N'(3), 1'b1);
    chk("lat_cycle1_valid", out_valid, 1'b0);
    tick(1'b0, 2'b00, '0, '0, 1'b1);
    chk("lat_cycle2_valid", out_valid, 1'b1);
    chk("lat_cycle2_S", $signed(S), 7);
    chk("lat_cycle2_ovf", ovf, 1'b0);
    drain();

    // SUB leaves the accumulator alone.
    tick(1'b1, 2'b11, '0, '0, 1'b1);
    tick(1'b1, 2'b10, N'(5), '0, 1'b1);
    tick(1'b1, 2'b01, N'(-8), N'(7), 1'b1);
    drain();
    chk("sub_S", last_s, -15);
    chk("sub_ovf", last_ovf, 1'b0);
    tick(1'b1, 2'b10, '0, '0, 1'b1);
    drain();
    chk("acc_after_sub", last_s, 5);

    // CLR then 19 back-to-back ACC of 7: crosses the positive limit on the last beat.
    tick(1'b1, 2'b11, '0, '0, 1'b1);
    for (int i = 0; i < 19; i++) tick(1'b1, 2'b10, N'(7), N'(i), 1'b1);
    drain();
    chk("acc18_S", prev_s, 126);
`ifdef ADD_PIPE_SAT_EN
    chk("acc19_S", last_s, 127);
`else
    chk("acc19_S", last_s, -123);
`endif
    chk("acc19_ovf", last_ovf, 1'b1);

    // Back-pressure with two beats in flight.
    tick(1'b1, 2'b00, N'(1), N'(1), 1'b1);
    tick(1'b1, 2'b00, N'(2), N'(2), 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b00, '0, '0, 1'b0);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_S", $signed(S), 2);
    end
    tick(1'b0, 2'b00, '0, '0, 1'b1);
    chk("release_S_next", $signed(S), 4);
    chk("release_valid_next", out_valid, 1'b1);
    drain();
    chk("release_last", last_s, 4);

    // Reset with ACC beats in flight discards them.
    tick(1'b1, 2'b11, '0, '0, 1'b1);
    tick(1'b1, 2'b10, N'(1), '0, 1'b1);
    tick(1'b1, 2'b10, N'(2), '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    m_acc     = 0;
    was_stall = 1'b0;
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b00, '0, '0, 1'b1);
      chk("postrst_no_stale", out_valid, 1'b0);
    end
    tick(1'b1, 2'b10, N'(-3), '0, 1'b1);
    drain();
    chk("postrst_acc", last_s, -3);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), N'($urandom), N'($urandom),
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
